frame_writer: RTL and testbench

- Downstream of the rasterizer.
- Accepts fragment writes: 18-bit pixel address (y*640+x) and 16-bit RGB565 colour.
- Buffers fragments in a small FIFO and writes them to the external 16-bit asynchronous framebuffer SRAM using a 3-phase write cycle.
- Also performs a full-frame clear on request, and supplies the backpressure the rasterizer uses to stall traversal.

---
 rtl/frame_writer_pkg.sv | 33 +++
 rtl/frame_writer_frag_fifo.sv | 57 +++++
 rtl/frame_writer.sv | 170 +++++++++++++++++
 tb/tb_frame_writer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_writer_pkg.sv
// rtl/frame_writer_pkg.sv - shared constants, FSM states and helpers for the frame writer
package frame_writer_pkg;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 400;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

    localparam int ADDR_W  = 18;
    localparam int COLOR_W = 16;

    // RGB565 field positions within a colour word
    localparam int RGB_R_LSB = 11;
    localparam int RGB_R_W   = 5;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_G_W   = 6;
    localparam int RGB_B_LSB = 0;
    localparam int RGB_B_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SETUP       = 3'd1,
        ST_PULSE       = 3'd2,
        ST_HOLD        = 3'd3,
        ST_CLEAR_SETUP = 3'd4,
        ST_CLEAR_PULSE = 3'd5,
        ST_CLEAR_HOLD  = 3'd6
    } fw_state_e;

    function automatic logic is_clear_state(fw_state_e s);
        return (s == ST_CLEAR_SETUP) || (s == ST_CLEAR_PULSE) || (s == ST_CLEAR_HOLD);
    endfunction

endpackage

// File: rtl/frame_writer_frag_fifo.sv
// rtl/frame_writer_frag_fifo.sv - synchronous fragment FIFO with show-ahead head entry
module frag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - fragment FIFO plus 3-phase async SRAM write engine with full-frame clear
module frame_writer
    import frame_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FB_PIXELS  = frame_writer_pkg::FB_PIXELS
) (
    input  logic               I_CLOCK,
    input  logic               I_RESET_N,
    input  logic               I_FRAG_VALID,
    input  logic [ADDR_W-1:0]  I_FRAG_ADDR,
    input  logic [COLOR_W-1:0] I_FRAG_COLOR,
    output logic               O_FRAG_READY,
    input  logic               I_CLEAR_REQ,
    input  logic [COLOR_W-1:0] I_CLEAR_COLOR,
    output logic               O_CLEAR_BUSY,
    output logic               O_IDLE,
    output logic               O_ADDR_ERR,
    output logic [ADDR_W-1:0]  O_SRAM_ADDR,
    output logic [COLOR_W-1:0] O_SRAM_DQ,
    output logic               O_SRAM_CE_N,
    output logic               O_SRAM_WE_N,
    output logic               O_SRAM_OE_N
);

    localparam int ENTRY_W = ADDR_W + COLOR_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] PIX_LIMIT = ADDR_W'(FB_PIXELS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

    fw_state_e          state_q, state_d;
    logic               clear_pending_q, clear_pending_d;
    logic [COLOR_W-1:0] clear_color_q;
    logic               ready_q, busy_q, idle_q, addr_err_q;
    logic [ADDR_W-1:0]  sram_addr_q;
    logic [COLOR_W-1:0] sram_dq_q;
    logic               ce_n_q, we_n_q;

    logic               accept, in_range, push, pop, clear_take;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count, count_d;

    assign accept     = I_FRAG_VALID && ready_q;
    assign in_range   = I_FRAG_ADDR < PIX_LIMIT;
    assign push       = accept && in_range && !fifo_full;
    assign clear_take = I_CLEAR_REQ && !clear_pending_q;

    frag_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i       (I_CLOCK),
        .rst_n_i     (I_RESET_N),
        .push_i      (push),
        .push_data_i ({I_FRAG_ADDR, I_FRAG_COLOR}),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        pop             = 1'b0;
        state_d         = state_q;
        clear_pending_d = clear_pending_q || clear_take;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_pending_q && fifo_empty) begin
                    state_d = ST_CLEAR_SETUP;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_PULSE;
            ST_PULSE: state_d = ST_HOLD;
            ST_HOLD: begin
                if (!fifo_empty && !clear_pending_q) begin
                    pop     = 1'b1;
                    state_d = ST_SETUP;
                end else if (clear_pending_q && fifo_empty) begin
                    state_d = ST_CLEAR_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR_SETUP: state_d = ST_CLEAR_PULSE;
            ST_CLEAR_PULSE: state_d = ST_CLEAR_HOLD;
            ST_CLEAR_HOLD: begin
                if (sram_addr_q == LAST_ADDR) begin
                    state_d         = ST_IDLE;
                    clear_pending_d = 1'b0;
                end else begin
                    state_d = ST_CLEAR_SETUP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = fifo_count;
        if (push && !pop) begin
            count_d = fifo_count + 1'b1;
        end else if (pop && !push) begin
            count_d = fifo_count - 1'b1;
        end
    end

    // Status flags are computed from next-state values so they are exact the cycle they appear
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q         <= ST_IDLE;
            clear_pending_q <= 1'b0;
            clear_color_q   <= '0;
            ready_q         <= 1'b0;
            busy_q          <= 1'b0;
            idle_q          <= 1'b1;
            addr_err_q      <= 1'b0;
            sram_addr_q     <= '0;
            sram_dq_q       <= '0;
            ce_n_q          <= 1'b1;
            we_n_q          <= 1'b1;
        end else begin
            state_q         <= state_d;
            clear_pending_q <= clear_pending_d;
            if (clear_take) begin
                clear_color_q <= I_CLEAR_COLOR;
            end
            ready_q    <= (count_d != CNT_W'(FIFO_DEPTH)) && !clear_pending_d && !is_clear_state(state_d);
            busy_q     <= clear_pending_d;
            idle_q     <= (count_d == '0) && (state_d == ST_IDLE) && !clear_pending_d;
            addr_err_q <= accept && !in_range;
            case (state_d)
                ST_SETUP: begin
                    sram_addr_q <= head[ENTRY_W-1:COLOR_W];
                    sram_dq_q   <= head[COLOR_W-1:0];
                    ce_n_q      <= 1'b0;
                    we_n_q      <= 1'b1;
                end
                ST_CLEAR_SETUP: begin
                    sram_addr_q <= (state_q == ST_CLEAR_HOLD) ? sram_addr_q + 1'b1 : '0;
                    sram_dq_q   <= clear_color_q;
                    ce_n_q      <= 1'b0;
                    we_n_q      <= 1'b1;
                end
                ST_PULSE, ST_CLEAR_PULSE: we_n_q <= 1'b0;
                ST_HOLD, ST_CLEAR_HOLD:   we_n_q <= 1'b1;
                default: begin
                    ce_n_q <= 1'b1;
                    we_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign O_FRAG_READY = ready_q;
    assign O_CLEAR_BUSY = busy_q;
    assign O_IDLE       = idle_q;
    assign O_ADDR_ERR   = addr_err_q;
    assign O_SRAM_ADDR  = sram_addr_q;
    assign O_SRAM_DQ    = sram_dq_q;
    assign O_SRAM_CE_N  = ce_n_q;
    assign O_SRAM_WE_N  = we_n_q;
    assign O_SRAM_OE_N  = 1'b1;

endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - randomized self-checking bench for frame_writer against an ordered write model
module tb_frame_writer;
    import frame_writer_pkg::*;

    localparam int TB_PIX = 3000;
    localparam int DEPTH  = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               frag_valid = 1'b0;
    logic [ADDR_W-1:0]  frag_addr = '0;
    logic [COLOR_W-1:0] frag_color = '0;
    logic               frag_ready;
    logic               clear_req = 1'b0;
    logic [COLOR_W-1:0] clear_color = '0;
    logic               clear_busy, idle, addr_err;
    logic [ADDR_W-1:0]  sram_addr;
    logic [COLOR_W-1:0] sram_dq;
    logic               ce_n, we_n, oe_n;

    frame_writer #(.FIFO_DEPTH(DEPTH), .FB_PIXELS(TB_PIX)) dut (
        .I_CLOCK(clk), .I_RESET_N(rst_n),
        .I_FRAG_VALID(frag_valid), .I_FRAG_ADDR(frag_addr), .I_FRAG_COLOR(frag_color),
        .O_FRAG_READY(frag_ready), .I_CLEAR_REQ(clear_req), .I_CLEAR_COLOR(clear_color),
        .O_CLEAR_BUSY(clear_busy), .O_IDLE(idle), .O_ADDR_ERR(addr_err),
        .O_SRAM_ADDR(sram_addr), .O_SRAM_DQ(sram_dq), .O_SRAM_CE_N(ce_n),
        .O_SRAM_WE_N(we_n), .O_SRAM_OE_N(oe_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ce_bad = 0;

    // Model: every accepted in-range fragment or clear pixel becomes one SRAM write, in order
    logic [ADDR_W-1:0]  exp_addr[$];
    logic [COLOR_W-1:0] exp_dq[$];
    logic [ADDR_W-1:0]  got_addr[$];
    logic [COLOR_W-1:0] got_dq[$];
    int                 got_t[$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (rst_n && we_n === 1'b0) begin
            got_addr.push_back(sram_addr);
            got_dq.push_back(sram_dq);
            got_t.push_back(cyc);
            if (ce_n !== 1'b0) ce_bad++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frag(input logic [ADDR_W-1:0] a, input logic [COLOR_W-1:0] c, output int waited);
        logic r;
        r = 1'b0;
        waited = 0;
        frag_valid = 1'b1;
        frag_addr  = a;
        frag_color = c;
        forever begin
            @(negedge clk);
            r = frag_ready;
            @(posedge clk);
            #1;
            if (r) break;
            waited++;
            if (waited > 300) begin
                checks++; errors++;
                $display("FAIL send_timeout addr %h never accepted, required READY within 300 cycles", a);
                break;
            end
        end
        frag_valid = 1'b0;
        if (r && int'(a) < TB_PIX) begin
            exp_addr.push_back(a);
            exp_dq.push_back(c);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (idle !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL idle_timeout O_IDLE=%b after %0d cycles, required 1", idle, budget);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({frag_ready, clear_busy, idle, addr_err, ce_n, we_n, oe_n} !== 7'b0010111) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 0010111",
                     {frag_ready, clear_busy, idle, addr_err, ce_n, we_n, oe_n});
        end
        checks++;
        if (sram_addr !== '0 || sram_dq !== '0) begin
            errors++;
            $display("FAIL reset_bus addr %h dq %h required 0/0", sram_addr, sram_dq);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        checks++;
        if (frag_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got %b required 0", frag_ready);
        end
        tick();
        checks++;
        if (frag_ready !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release ready %b idle %b required 1/1", frag_ready, idle);
        end
    endtask

    task automatic test_single();
        int w;
        send_frag(18'h00A3C, 16'hF800, w);
        tick();
        checks++;
        if (sram_addr !== 18'h00A3C || sram_dq !== 16'hF800 || ce_n !== 1'b0 || we_n !== 1'b1) begin
            errors++;
            $display("FAIL single_setup addr %h dq %h ce %b we %b required 00a3c f800 0 1",
                     sram_addr, sram_dq, ce_n, we_n);
        end
        tick();
        checks++;
        if (we_n !== 1'b0 || ce_n !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse we %b ce %b required 0/0", we_n, ce_n);
        end
        tick();
        checks++;
        if (we_n !== 1'b1 || ce_n !== 1'b0 || sram_addr !== 18'h00A3C) begin
            errors++;
            $display("FAIL single_hold we %b ce %b addr %h required 1 0 00a3c", we_n, ce_n, sram_addr);
        end
        tick();
        checks++;
        if (idle !== 1'b1 || ce_n !== 1'b1) begin
            errors++;
            $display("FAIL single_idle idle %b ce %b required 1/1", idle, ce_n);
        end
    endtask

    task automatic test_back_to_back();
        int base, w, stalls, bad;
        base = exp_addr.size();
        stalls = 0;
        for (int i = 0; i < 12; i++) begin
            send_frag(18'($urandom_range(0, TB_PIX - 1)), 16'($urandom), w);
            stalls += w;
        end
        checks++;
        if (stalls != 0 || frag_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_fill stalls %0d ready %b required 0 stalls and ready 0 when full", stalls, frag_ready);
        end
        send_frag(18'($urandom_range(0, TB_PIX - 1)), 16'($urandom), w);
        checks++;
        if (w != 2) begin
            errors++;
            $display("FAIL b2b_stall waited %0d cycles required 2", w);
        end
        wait_idle(100);
        bad = 0;
        checks++;
        if (got_t.size() < base + 13) begin
            errors++;
            $display("FAIL b2b_count got %0d writes required %0d", got_t.size(), base + 13);
        end else begin
            for (int i = base; i < base + 12; i++)
                if (got_t[i + 1] - got_t[i] != 3) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL b2b_rate %0d write gaps differ from 3 cycles, required 0", bad);
            end
        end
    endtask

    task automatic test_addr_err();
        int w, n0;
        n0 = got_addr.size();
        send_frag(18'd256000, 16'h1234, w);
        checks++;
        if (addr_err !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL addr_err_pulse err %b idle %b required 1/1", addr_err, idle);
        end
        tick();
        checks++;
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL addr_err_width got %b required 0", addr_err);
        end
        send_frag(18'(TB_PIX), 16'h5555, w);
        checks++;
        if (addr_err !== 1'b1) begin
            errors++;
            $display("FAIL addr_err_boundary got %b required 1", addr_err);
        end
        repeat (6) tick();
        checks++;
        if (got_addr.size() != n0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL addr_err_nowrite writes %0d idle %b required %0d/1", got_addr.size(), idle, n0);
        end
        send_frag(18'(TB_PIX - 1), 16'hAAAA, w);
        checks++;
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL addr_last_valid err %b required 0", addr_err);
        end
        wait_idle(50);
    endtask

    task automatic test_random();
        int w;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 18'($urandom_range(TB_PIX, 262143));
                1, 2, 3: a = 18'($urandom_range(0, 15));
                default: a = 18'($urandom_range(0, TB_PIX - 1));
            endcase
            send_frag(a, 16'($urandom), w);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle(300);
    endtask

    task automatic test_clear();
        int w, base, n, ready_bad, idx0;
        base = exp_addr.size();
        for (int i = 0; i < 3; i++)
            send_frag(18'($urandom_range(0, TB_PIX - 1)), 16'($urandom), w);
        clear_req = 1'b1;
        clear_color = 16'h001F;
        tick();
        clear_req = 1'b0;
        clear_color = 16'($urandom);
        for (int i = 0; i < TB_PIX; i++) begin
            exp_addr.push_back(18'(i));
            exp_dq.push_back(16'h001F);
        end
        checks++;
        if (clear_busy !== 1'b1 || frag_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_start busy %b ready %b required 1/0", clear_busy, frag_ready);
        end
        n = 0;
        ready_bad = 0;
        while (clear_busy === 1'b1 && n < 3 * TB_PIX + 100) begin
            if (frag_ready !== 1'b0) ready_bad++;
            if (n == 1000) begin
                clear_req = 1'b1;
                clear_color = 16'hFFFF;
            end else begin
                clear_req = 1'b0;
            end
            tick();
            n++;
        end
        clear_req = 1'b0;
        checks++;
        if (clear_busy !== 1'b0 || ready_bad != 0) begin
            errors++;
            $display("FAIL clear_busy_ready busy %b ready_high_cycles %0d required 0/0", clear_busy, ready_bad);
        end
        wait_idle(50);
        checks++;
        if (frag_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_ready_return got %b required 1", frag_ready);
        end
        idx0 = base + 3;
        checks++;
        if (got_t.size() < idx0 + TB_PIX) begin
            errors++;
            $display("FAIL clear_count got %0d writes required %0d", got_t.size(), idx0 + TB_PIX);
        end else if (got_t[idx0 + TB_PIX - 1] - got_t[idx0] != 3 * (TB_PIX - 1)) begin
            errors++;
            $display("FAIL clear_duration got %0d cycles required %0d",
                     got_t[idx0 + TB_PIX - 1] - got_t[idx0], 3 * (TB_PIX - 1));
        end
    endtask

    task automatic test_reset_mid_write();
        int w, base, n;
        base = exp_addr.size();
        for (int i = 0; i < 3; i++)
            send_frag(18'($urandom_range(0, TB_PIX - 1)), 16'($urandom), w);
        n = 0;
        while (we_n !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (we_n !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_pulse WE_N=%b required 0 before reset", we_n);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (we_n !== 1'b1 || ce_n !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL rst_async we %b ce %b idle %b required 1/1/1", we_n, ce_n, idle);
        end
        repeat (3) exp_addr.pop_back();
        repeat (3) exp_dq.pop_back();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        checks++;
        if (got_addr.size() != base || idle !== 1'b1 || frag_ready !== 1'b1 || clear_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_flush writes %0d idle %b ready %b busy %b required %0d/1/1/0",
                     got_addr.size(), idle, frag_ready, clear_busy, base);
        end
    endtask

    task automatic test_ordering();
        int n, bad_idx;
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL write_count got %0d required %0d", got_addr.size(), exp_addr.size());
        end
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        bad_idx = -1;
        for (int i = 0; i < n; i++) begin
            if (got_addr[i] !== exp_addr[i] || got_dq[i] !== exp_dq[i]) begin
                bad_idx = i;
                break;
            end
        end
        checks++;
        if (bad_idx >= 0) begin
            errors++;
            $display("FAIL write_order idx %0d got %h/%h required %h/%h", bad_idx,
                     got_addr[bad_idx], got_dq[bad_idx], exp_addr[bad_idx], exp_dq[bad_idx]);
        end
        checks++;
        if (ce_bad != 0) begin
            errors++;
            $display("FAIL ce_during_we got %0d writes with CE_N high required 0", ce_bad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_addr_err();
        test_random();
        test_clear();
        test_reset_mid_write();
        test_ordering();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
